// File: rtl/reg_stack_loader.sv
// Push-button front end for the register stack: debounced buttons enter hex digits
// into a preview word and commit it as a single-cycle register write.

module reg_stack_loader_db #(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic CLK,
    input  logic Reset,
    input  logic raw,
    output logic evt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1, s2, lvl, lvl_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl   <= 1'b0;
            lvl_q <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            lvl_q <= lvl;
            // Count consecutive samples that disagree with the accepted level.
            if (s2 != lvl) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    lvl <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign evt = lvl & ~lvl_q;
endmodule

module reg_stack_loader #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter bit SKIP_ZERO       = 1'b1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Btn_Digit,
    input  logic        Btn_Commit,
    input  logic        Btn_Addr,
    input  logic [3:0]  Nibble,
    input  logic [4:0]  Start_Addr,
    output logic [31:0] Preview,
    output logic [3:0]  Digit_Cnt,
    output logic [4:0]  W_Addr,
    output logic [31:0] W_Data,
    output logic        Write_Reg,
    output logic        Busy
);
    typedef enum logic [1:0] {ENTRY, SETUP, STROBE, HOLD} state_t;

    state_t      state, state_n;
    logic [2:0]  btn_raw, btn_evt;
    logic [31:0] preview_n, wdata_n;
    logic [3:0]  cnt_n;
    logic [4:0]  waddr_n, waddr_plus, waddr_inc;

    assign btn_raw = {Btn_Addr, Btn_Commit, Btn_Digit};

    reg_stack_loader_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [2:0] (
        .CLK   (CLK),
        .Reset (Reset),
        .raw   (btn_raw),
        .evt   (btn_evt)
    );

    assign waddr_plus = W_Addr + 5'd1;
    assign waddr_inc  = (SKIP_ZERO && waddr_plus == 5'd0) ? 5'd1 : waddr_plus;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state     <= ENTRY;
            Preview   <= '0;
            Digit_Cnt <= '0;
            W_Addr    <= '0;
            W_Data    <= '0;
        end else begin
            state     <= state_n;
            Preview   <= preview_n;
            Digit_Cnt <= cnt_n;
            W_Addr    <= waddr_n;
            W_Data    <= wdata_n;
        end
    end

    always_comb begin
        state_n   = state;
        preview_n = Preview;
        cnt_n     = Digit_Cnt;
        waddr_n   = W_Addr;
        wdata_n   = W_Data;
        Write_Reg = 1'b0;
        Busy      = 1'b1;
        case (state)
            ENTRY: begin
                Busy = 1'b0;
                // Priority Addr > Commit > Digit; losers are dropped.
                if (btn_evt[2]) begin
                    waddr_n   = Start_Addr;
                    preview_n = '0;
                    cnt_n     = '0;
                end else if (btn_evt[1]) begin
                    if (Digit_Cnt != 4'd0) begin
                        wdata_n = Preview;
                        state_n = SETUP;
                    end
                end else if (btn_evt[0]) begin
                    preview_n = {Preview[27:0], Nibble};
                    if (Digit_Cnt != 4'd8) cnt_n = Digit_Cnt + 4'd1;
                end
            end
            SETUP:  state_n = STROBE;
            STROBE: begin
                Write_Reg = 1'b1;
                state_n   = HOLD;
            end
            HOLD: begin
                state_n   = ENTRY;
                preview_n = '0;
                cnt_n     = '0;
                waddr_n   = waddr_inc;
            end
            default: state_n = ENTRY;
        endcase
    end
endmodule

// File: tb/tb_reg_stack_loader.sv
// Scenario bench for reg_stack_loader: expected writes are queued as stimulus is
// driven and matched against each Write_Reg strobe.

module tb_reg_stack_loader;
    logic        CLK = 1'b0;
    logic        Reset;
    logic        Btn_Digit, Btn_Commit, Btn_Addr;
    logic [3:0]  Nibble;
    logic [4:0]  Start_Addr;
    logic [31:0] Preview, W_Data, Preview0, W_Data0;
    logic [3:0]  Digit_Cnt, Digit_Cnt0;
    logic [4:0]  W_Addr, W_Addr0;
    logic        Write_Reg, Busy, Write_Reg0, Busy0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    logic [36:0] exp_q[$];

    always #5 CLK = ~CLK;

    reg_stack_loader #(.DEBOUNCE_CYCLES(4), .SKIP_ZERO(1'b1)) dut (
        .CLK(CLK), .Reset(Reset), .Btn_Digit(Btn_Digit), .Btn_Commit(Btn_Commit),
        .Btn_Addr(Btn_Addr), .Nibble(Nibble), .Start_Addr(Start_Addr), .Preview(Preview),
        .Digit_Cnt(Digit_Cnt), .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg), .Busy(Busy)
    );

    reg_stack_loader #(.DEBOUNCE_CYCLES(4), .SKIP_ZERO(1'b0)) dut0 (
        .CLK(CLK), .Reset(Reset), .Btn_Digit(Btn_Digit), .Btn_Commit(Btn_Commit),
        .Btn_Addr(Btn_Addr), .Nibble(Nibble), .Start_Addr(Start_Addr), .Preview(Preview0),
        .Digit_Cnt(Digit_Cnt0), .W_Addr(W_Addr0), .W_Data(W_Data0), .Write_Reg(Write_Reg0), .Busy(Busy0)
    );

    task automatic press(input logic [2:0] which);
        @(posedge CLK); #1;
        {Btn_Addr, Btn_Commit, Btn_Digit} = which;
        repeat (12) @(posedge CLK);
        #1;
        {Btn_Addr, Btn_Commit, Btn_Digit} = 3'b000;
        repeat (10) @(posedge CLK);
        #1;
    endtask

    task automatic digit(input logic [3:0] n);
        Nibble = n;
        press(3'b001);
    endtask

    task automatic load_addr(input logic [4:0] a);
        Start_Addr = a;
        press(3'b100);
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        {Btn_Addr, Btn_Commit, Btn_Digit} = 3'b000;
        Nibble = 4'h0; Start_Addr = 5'd0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if ({Preview, Digit_Cnt, W_Addr, W_Data, Write_Reg, Busy} !== 75'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h %h %h %h %b %b, expected all zero",
                     Preview, Digit_Cnt, W_Addr, W_Data, Write_Reg, Busy);
        end
        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic test_basic_commit;
        int w0;
        load_addr(5'd5);
        digit(4'h1); digit(4'h2); digit(4'hA); digit(4'hF);
        n_checks++;
        if (Preview !== 32'h000012AF || Digit_Cnt !== 4'd4) begin
            n_fail++;
            $display("FAIL basic_preview: got %h/%0d expected 000012af/4", Preview, Digit_Cnt);
        end
        w0 = n_writes;
        exp_q.push_back({5'd5, 32'h000012AF});
        press(3'b010);
        n_checks++;
        if (W_Addr !== 5'd6 || Preview !== 32'd0 || Digit_Cnt !== 4'd0 || n_writes != w0 + 1) begin
            n_fail++;
            $display("FAIL basic_after: addr %0d preview %h cnt %0d writes %0d, expected 6 0 0 %0d",
                     W_Addr, Preview, Digit_Cnt, n_writes - w0, 1);
        end
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 9; i++) digit(4'(i));
        n_checks++;
        if (Digit_Cnt !== 4'd8 || Preview !== 32'h23456789) begin
            n_fail++;
            $display("FAIL overflow_preview: got %h/%0d expected 23456789/8", Preview, Digit_Cnt);
        end
        exp_q.push_back({5'd6, 32'h23456789});
        press(3'b010);
        n_checks++;
        if (W_Addr !== 5'd7) begin
            n_fail++;
            $display("FAIL overflow_addr: got %0d expected 7", W_Addr);
        end
    endtask

    task automatic test_bounce;
        int k;
        Nibble = 4'hC;
        @(posedge CLK); #1;
        for (int r = 0; r < 6; r++) begin
            Btn_Digit = 1'b1;
            repeat (3) @(posedge CLK);
            #1;
            Btn_Digit = 1'b0;
            repeat (2) @(posedge CLK);
            #1;
        end
        n_checks++;
        if (Digit_Cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL bounce_glitch: cnt %0d expected 0", Digit_Cnt);
        end
        Btn_Digit = 1'b1;
        k = 0;
        while (k < 20) begin
            @(posedge CLK);
            k++;
            #1;
            if (Digit_Cnt !== 4'd0) break;
        end
        n_checks++;
        if (k != 7) begin
            n_fail++;
            $display("FAIL bounce_latency: got %0d cycles expected 7", k);
        end
        repeat (10) @(posedge CLK);
        #1;
        Btn_Digit = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        n_checks++;
        if (Digit_Cnt !== 4'd1 || Preview !== 32'h0000000C) begin
            n_fail++;
            $display("FAIL bounce_single: got %h/%0d expected 0000000c/1", Preview, Digit_Cnt);
        end
    endtask

    task automatic test_wrap;
        load_addr(5'd31);
        digit(4'h1);
        exp_q.push_back({5'd31, 32'h1});
        press(3'b010);
        n_checks++;
        if (W_Addr !== 5'd1 || W_Addr0 !== 5'd0) begin
            n_fail++;
            $display("FAIL wrap_first: skip %0d plain %0d expected 1 0", W_Addr, W_Addr0);
        end
        digit(4'h2);
        exp_q.push_back({5'd1, 32'h2});
        press(3'b010);
        n_checks++;
        if (W_Addr !== 5'd2 || W_Addr0 !== 5'd1) begin
            n_fail++;
            $display("FAIL wrap_second: skip %0d plain %0d expected 2 1", W_Addr, W_Addr0);
        end
    endtask

    task automatic test_ignored;
        int w0;
        load_addr(5'd9);
        w0 = n_writes;
        press(3'b010);
        n_checks++;
        if (n_writes != w0 || W_Addr !== 5'd9 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_commit: writes %0d addr %0d busy %b expected 0 9 0",
                     n_writes - w0, W_Addr, Busy);
        end
        digit(4'h3);
        Start_Addr = 5'd12;
        press(3'b110);
        n_checks++;
        if (n_writes != w0 || W_Addr !== 5'd12 || Preview !== 32'd0 || Digit_Cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL addr_over_commit: writes %0d addr %0d preview %h cnt %0d expected 0 12 0 0",
                     n_writes - w0, W_Addr, Preview, Digit_Cnt);
        end
    endtask

    task automatic test_busy_and_reset;
        int k, w0;
        digit(4'h5);
        exp_q.push_back({5'd12, 32'h5});
        @(posedge CLK); #1;
        Btn_Commit = 1'b1;
        @(posedge CLK); #1;
        Nibble = 4'h6;
        Btn_Digit = 1'b1;
        k = 0;
        while (k < 20) begin
            @(negedge CLK);
            k++;
            if (Write_Reg === 1'b1) break;
        end
        n_checks++;
        if (k >= 20 || Preview !== 32'h5) begin
            n_fail++;
            $display("FAIL busy_digit: strobe wait %0d preview %h expected <20 00000005", k, Preview);
        end
        repeat (12) @(posedge CLK);
        #1;
        {Btn_Commit, Btn_Digit} = 2'b00;
        repeat (10) @(posedge CLK);
        #1;
        n_checks++;
        if (Digit_Cnt !== 4'd0 || W_Addr !== 5'd13) begin
            n_fail++;
            $display("FAIL busy_after: cnt %0d addr %0d expected 0 13", Digit_Cnt, W_Addr);
        end

        digit(4'h7);
        exp_q.push_back({5'd13, 32'h7});
        @(posedge CLK); #1;
        Btn_Commit = 1'b1;
        k = 0;
        while (k < 20) begin
            @(negedge CLK);
            k++;
            if (Write_Reg === 1'b1) break;
        end
        #2;
        Reset = 1'b0;
        #1;
        n_checks++;
        if (k >= 20 || {Preview, Digit_Cnt, W_Addr, W_Data, Write_Reg, Busy} !== 75'd0) begin
            n_fail++;
            $display("FAIL reset_in_strobe: wait %0d outs %h %h %h %h %b %b expected all zero",
                     k, Preview, Digit_Cnt, W_Addr, W_Data, Write_Reg, Busy);
        end
        Btn_Commit = 1'b0;
        w0 = n_writes;
        repeat (3) @(posedge CLK);
        #1;
        Reset = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        n_checks++;
        if (n_writes != w0 || Busy !== 1'b0 || W_Addr !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_no_replay: writes %0d busy %b addr %0d expected 0 0 0",
                     n_writes - w0, Busy, W_Addr);
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge CLK);
                if (Write_Reg === 1'b1) begin
                    n_writes++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_write: addr %0d data %h with no write expected",
                                 W_Addr, W_Data);
                    end else begin
                        logic [36:0] e;
                        e = exp_q.pop_front();
                        if ({W_Addr, W_Data} !== e) begin
                            n_fail++;
                            $display("FAIL write_txn: got addr %0d data %h expected addr %0d data %h",
                                     W_Addr, W_Data, e[36:32], e[31:0]);
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_basic_commit();
        test_overflow();
        test_bounce();
        test_wrap();
        test_ignored();
        test_busy_and_reset();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_writes: %0d queued writes never seen, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
